// File: rtl/link_align_pkg.sv
// Shared definitions for the link alignment supervisor: state encoding,
// power-on aligner configuration and small arithmetic helpers.
package link_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_PHY = 3'd1,
        ST_REALIGN  = 3'd2,
        ST_SEARCH   = 3'd3,
        ST_BACKOFF  = 3'd4,
        ST_LOCKED   = 3'd5,
        ST_FADE     = 3'd6,
        ST_GT_RESET = 3'd7
    } sup_state_e;

    localparam int TMR_W = 32;

    typedef struct packed {
        logic [5:0]  err_th;
        logic [7:0]  verify_cnt_max;
        logic [23:0] soft_loss_to;
        logic [23:0] hard_loss_to;
    } align_cfg_t;

    localparam align_cfg_t CFG_RST = '{
        err_th:         6'd4,
        verify_cnt_max: 8'd8,
        soft_loss_to:   24'd78125,
        hard_loss_to:   24'd312500
    };

    // A zero verify count would never confirm lock, and a hard timeout
    // shorter than the soft one would skip the degraded phase entirely.
    function automatic align_cfg_t sanitize_cfg(input align_cfg_t c);
        align_cfg_t r;
        r = c;
        if (c.verify_cnt_max == 8'd0)
            r.verify_cnt_max = 8'd1;
        if (c.hard_loss_to < c.soft_loss_to)
            r.hard_loss_to = c.soft_loss_to;
        return r;
    endfunction

    // Timer value that keeps a state resident for exactly n cycles.
    function automatic logic [TMR_W-1:0] dwell_load(input int unsigned n);
        return (n == 0) ? '0 : TMR_W'(n - 1);
    endfunction

    function automatic logic [TMR_W-1:0] backoff_load(input logic [TMR_W-1:0] base,
                                                      input logic [3:0] retry);
        logic [3:0]       sh;
        logic [TMR_W-1:0] len;
        sh  = (retry == 4'd0) ? 4'd0 : ((retry > 4'd8) ? 4'd7 : retry - 4'd1);
        len = base << sh;
        return (len == '0) ? '0 : len - TMR_W'(1);
    endfunction

endpackage

// File: rtl/link_sup_timer.sv
// Loadable down-counter shared by all timed supervisor states; expired_o is
// high whenever the count has reached zero.
module link_sup_timer
    import link_align_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= load_val_i;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - W'(1);
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/link_align_supervisor.sv
// Supervises word alignment bring-up, retries with exponential backoff and
// transceiver RX reset escalation. Define LINK_SUP_STATS_EN for relock/fade counters.
module link_align_supervisor
    import link_align_pkg::*;
#(
    parameter int SEARCH_TIMEOUT  = 65536,
    parameter int MAX_RETRIES     = 8,
    parameter int REALIGN_HOLD    = 4,
    parameter int BACKOFF_BASE    = 256,
    parameter int GT_RESET_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_enable,
    input  logic        i_rx_reset_done,
    input  logic        i_rx_cdr_stable,
    input  logic        i_bit_locked,
    input  logic        i_bit_locked_soft,
    input  logic        i_force_realign,
    input  logic [5:0]  i_cfg_err_th,
    input  logic [7:0]  i_cfg_verify_cnt_max,
    input  logic [23:0] i_cfg_soft_loss_to,
    input  logic [23:0] i_cfg_hard_loss_to,
    output logic [5:0]  o_cfg_err_th,
    output logic [7:0]  o_cfg_verify_cnt_max,
    output logic [23:0] o_cfg_soft_loss_to,
    output logic [23:0] o_cfg_hard_loss_to,
    output logic        o_realign_req,
    output logic        o_gt_rx_reset,
    output logic        o_link_up,
    output logic        o_link_degraded,
    output logic [2:0]  o_state,
    output logic [3:0]  o_retry_cnt
`ifdef LINK_SUP_STATS_EN
   ,output logic [15:0] o_relock_cnt,
    output logic [15:0] o_fade_cnt
`endif
);

    localparam logic [TMR_W-1:0] LD_REALIGN = dwell_load(REALIGN_HOLD);
    localparam logic [TMR_W-1:0] LD_SEARCH  = dwell_load(SEARCH_TIMEOUT);
    localparam logic [TMR_W-1:0] LD_GT_RST  = dwell_load(GT_RESET_CYCLES);
    localparam logic [TMR_W-1:0] BO_BASE    = TMR_W'(BACKOFF_BASE);

    sup_state_e       state_q, state_d;
    logic [3:0]       retry_q, retry_d, retry_inc;
    align_cfg_t       cfg_q, cfg_d, cfg_req;
    logic             tmr_load, tmr_exp;
    logic [TMR_W-1:0] tmr_val;
    logic             phy_ok;

    assign phy_ok    = i_rx_reset_done && i_rx_cdr_stable;
    assign retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
    assign cfg_req   = '{err_th:         i_cfg_err_th,
                         verify_cnt_max: i_cfg_verify_cnt_max,
                         soft_loss_to:   i_cfg_soft_loss_to,
                         hard_loss_to:   i_cfg_hard_loss_to};

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        if (!i_enable) begin
            state_d = ST_IDLE;
        end else if (!phy_ok && (state_q inside {ST_REALIGN, ST_SEARCH, ST_BACKOFF,
                                                 ST_LOCKED, ST_FADE})) begin
            state_d = ST_WAIT_PHY;
            retry_d = 4'd0;
        end else if (i_force_realign && (state_q inside {ST_SEARCH, ST_BACKOFF,
                                                         ST_LOCKED, ST_FADE})) begin
            state_d = ST_REALIGN;
        end else begin
            unique case (state_q)
                ST_IDLE:     state_d = ST_WAIT_PHY;
                ST_WAIT_PHY: if (phy_ok) state_d = ST_REALIGN;
                ST_REALIGN:  if (tmr_exp) state_d = ST_SEARCH;
                ST_SEARCH: begin
                    if (i_bit_locked) begin
                        state_d = ST_LOCKED;
                        retry_d = 4'd0;
                    end else if (tmr_exp) begin
                        retry_d = retry_inc;
                        state_d = (int'(retry_inc) >= MAX_RETRIES) ? ST_GT_RESET : ST_BACKOFF;
                    end
                end
                ST_BACKOFF:  if (tmr_exp) state_d = ST_REALIGN;
                ST_LOCKED: begin
                    if (!i_bit_locked)
                        state_d = i_bit_locked_soft ? ST_FADE : ST_SEARCH;
                end
                ST_FADE: begin
                    if (i_bit_locked)
                        state_d = ST_LOCKED;
                    else if (!i_bit_locked_soft)
                        state_d = ST_SEARCH;
                end
                ST_GT_RESET: begin
                    if (tmr_exp) begin
                        state_d = ST_WAIT_PHY;
                        retry_d = 4'd0;
                    end
                end
                default:     state_d = ST_IDLE;
            endcase
        end

        // Every entry into a timed state restarts the shared timer.
        if (state_d != state_q) begin
            unique case (state_d)
                ST_REALIGN:  begin tmr_load = 1'b1; tmr_val = LD_REALIGN; end
                ST_SEARCH:   begin tmr_load = 1'b1; tmr_val = LD_SEARCH;  end
                ST_BACKOFF:  begin tmr_load = 1'b1; tmr_val = backoff_load(BO_BASE, retry_d); end
                ST_GT_RESET: begin tmr_load = 1'b1; tmr_val = LD_GT_RST;  end
                default:     ;
            endcase
        end

        cfg_d = cfg_q;
        if (state_d == ST_REALIGN && state_q != ST_REALIGN)
            cfg_d = sanitize_cfg(cfg_req);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            retry_q <= 4'd0;
            cfg_q   <= CFG_RST;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            cfg_q   <= cfg_d;
        end
    end

    link_sup_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_exp)
    );

    assign o_state              = state_q;
    assign o_retry_cnt          = retry_q;
    assign o_realign_req        = (state_q == ST_REALIGN);
    assign o_gt_rx_reset        = (state_q == ST_GT_RESET);
    assign o_link_up            = (state_q == ST_LOCKED);
    assign o_link_degraded      = (state_q == ST_FADE);
    assign o_cfg_err_th         = cfg_q.err_th;
    assign o_cfg_verify_cnt_max = cfg_q.verify_cnt_max;
    assign o_cfg_soft_loss_to   = cfg_q.soft_loss_to;
    assign o_cfg_hard_loss_to   = cfg_q.hard_loss_to;

`ifdef LINK_SUP_STATS_EN
    logic [15:0] relock_q, fade_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            relock_q <= 16'd0;
            fade_q   <= 16'd0;
        end else if (state_q == ST_IDLE) begin
            relock_q <= 16'd0;
            fade_q   <= 16'd0;
        end else begin
            if (state_q == ST_SEARCH && state_d == ST_LOCKED && relock_q != 16'hFFFF)
                relock_q <= relock_q + 16'd1;
            if (state_q == ST_LOCKED && state_d == ST_FADE && fade_q != 16'hFFFF)
                fade_q <= fade_q + 16'd1;
        end
    end

    assign o_relock_cnt = relock_q;
    assign o_fade_cnt   = fade_q;
`endif

endmodule

// File: tb/tb_link_align_supervisor.sv
// Directed bench for link_align_supervisor: expected state transitions are
// queued as stimulus is applied and matched against each observed change.
module tb_link_align_supervisor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        i_enable, i_rx_reset_done, i_rx_cdr_stable;
    logic        i_bit_locked, i_bit_locked_soft, i_force_realign;
    logic [5:0]  i_cfg_err_th;
    logic [7:0]  i_cfg_verify_cnt_max;
    logic [23:0] i_cfg_soft_loss_to, i_cfg_hard_loss_to;
    logic [5:0]  o_cfg_err_th;
    logic [7:0]  o_cfg_verify_cnt_max;
    logic [23:0] o_cfg_soft_loss_to, o_cfg_hard_loss_to;
    logic        o_realign_req, o_gt_rx_reset, o_link_up, o_link_degraded;
    logic [2:0]  o_state;
    logic [3:0]  o_retry_cnt;
`ifdef LINK_SUP_STATS_EN
    logic [15:0] o_relock_cnt, o_fade_cnt;
`endif

    link_align_supervisor #(
        .SEARCH_TIMEOUT  (100),
        .MAX_RETRIES     (2),
        .REALIGN_HOLD    (4),
        .BACKOFF_BASE    (8),
        .GT_RESET_CYCLES (64)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_enable             (i_enable),
        .i_rx_reset_done      (i_rx_reset_done),
        .i_rx_cdr_stable      (i_rx_cdr_stable),
        .i_bit_locked         (i_bit_locked),
        .i_bit_locked_soft    (i_bit_locked_soft),
        .i_force_realign      (i_force_realign),
        .i_cfg_err_th         (i_cfg_err_th),
        .i_cfg_verify_cnt_max (i_cfg_verify_cnt_max),
        .i_cfg_soft_loss_to   (i_cfg_soft_loss_to),
        .i_cfg_hard_loss_to   (i_cfg_hard_loss_to),
        .o_cfg_err_th         (o_cfg_err_th),
        .o_cfg_verify_cnt_max (o_cfg_verify_cnt_max),
        .o_cfg_soft_loss_to   (o_cfg_soft_loss_to),
        .o_cfg_hard_loss_to   (o_cfg_hard_loss_to),
        .o_realign_req        (o_realign_req),
        .o_gt_rx_reset        (o_gt_rx_reset),
        .o_link_up            (o_link_up),
        .o_link_degraded      (o_link_degraded),
        .o_state              (o_state),
        .o_retry_cnt          (o_retry_cnt)
`ifdef LINK_SUP_STATS_EN
       ,.o_relock_cnt         (o_relock_cnt),
        .o_fade_cnt           (o_fade_cnt)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;
    int sb_q[$];
    bit trace_en = 1'b0;
    int prev_st = 0;
    int dur = 0;
    int dur_last = 0;
    int rq_cnt = 0;
    int gt_cnt = 0;
    int rq_base = 0;
    int gt_base = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock: sample at the falling edge, track pulse widths, state
    // residency and compare each state change against the queued expectation.
    task automatic tick();
        int e;
        @(negedge clk);
        if (o_realign_req) rq_cnt++;
        if (o_gt_rx_reset) gt_cnt++;
        if (int'(o_state) != prev_st) begin
            if (trace_en) begin
                n_chk++;
                e = (sb_q.size() != 0) ? sb_q.pop_front() : -1;
                assert (int'(o_state) === e) n_pass++;
                else $error("FAIL trace: observed state %0d expected %0d", o_state, e);
            end
            dur_last = dur;
            dur      = 1;
            prev_st  = int'(o_state);
        end else begin
            dur++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_state(input int s, input int budget, input string tag);
        int k;
        k = 0;
        while (int'(o_state) != s && k < budget) begin
            tick();
            k++;
        end
        check(tag, o_state, s);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"},    o_state, 0);
        check({tag, "_retry"},    o_retry_cnt, 0);
        check({tag, "_realign"},  o_realign_req, 0);
        check({tag, "_gtrst"},    o_gt_rx_reset, 0);
        check({tag, "_linkup"},   o_link_up, 0);
        check({tag, "_degraded"}, o_link_degraded, 0);
        check({tag, "_err_th"},   o_cfg_err_th, 4);
        check({tag, "_verify"},   o_cfg_verify_cnt_max, 8);
        check({tag, "_soft"},     o_cfg_soft_loss_to, 78125);
        check({tag, "_hard"},     o_cfg_hard_loss_to, 312500);
`ifdef LINK_SUP_STATS_EN
        check({tag, "_relock"},   o_relock_cnt, 0);
        check({tag, "_fade"},     o_fade_cnt, 0);
`endif
    endtask

    initial begin
        rst_n                = 1'b0;
        i_enable             = 1'b0;
        i_rx_reset_done      = 1'b0;
        i_rx_cdr_stable      = 1'b0;
        i_bit_locked         = 1'b0;
        i_bit_locked_soft    = 1'b0;
        i_force_realign      = 1'b0;
        i_cfg_err_th         = 6'd10;
        i_cfg_verify_cnt_max = 8'd0;
        i_cfg_soft_loss_to   = 24'd500;
        i_cfg_hard_loss_to   = 24'd10;
        ticks(3);
        check_reset_outputs("por");
        rst_n = 1'b1;
        ticks(2);
        check("idle_disabled", o_state, 0);

        // Bring-up with sanitised configuration
        trace_en = 1'b1;
        sb_q.push_back(1); sb_q.push_back(2); sb_q.push_back(3);
        rq_base = rq_cnt;
        i_enable        = 1'b1;
        i_rx_reset_done = 1'b1;
        i_rx_cdr_stable = 1'b1;
        wait_state(3, 20, "bringup_search");
        check("realign_hold", rq_cnt - rq_base, 4);
        ticks(50);
        sb_q.push_back(5);
        i_bit_locked      = 1'b1;
        i_bit_locked_soft = 1'b1;
        tick();
        check("lock_state", o_state, 5);
        check("lock_linkup", o_link_up, 1);
        check("lock_retry", o_retry_cnt, 0);
        check("cfg_err_th", o_cfg_err_th, 10);
        check("cfg_verify_min", o_cfg_verify_cnt_max, 1);
        check("cfg_soft", o_cfg_soft_loss_to, 500);
        check("cfg_hard_clamp", o_cfg_hard_loss_to, 500);
        i_cfg_err_th         = 6'd20;
        i_cfg_verify_cnt_max = 8'd7;
        i_cfg_soft_loss_to   = 24'd1000;
        i_cfg_hard_loss_to   = 24'd2000;
        ticks(10);
        check("cfg_hold_verify", o_cfg_verify_cnt_max, 1);
        check("cfg_hold_hard", o_cfg_hard_loss_to, 500);
        check("cfg_hold_err_th", o_cfg_err_th, 10);
        check("sb_drain_bringup", sb_q.size(), 0);

        // Soft fade and recovery
        sb_q.push_back(6);
        i_bit_locked = 1'b0;
        tick();
        check("fade_state", o_state, 6);
        check("fade_degraded", o_link_degraded, 1);
        check("fade_linkup", o_link_up, 0);
        ticks(999);
        check("fade_held", o_state, 6);
        sb_q.push_back(5);
        i_bit_locked = 1'b1;
        tick();
        check("fade_recover_linkup", o_link_up, 1);
        check("fade_recover_degraded", o_link_degraded, 0);
`ifdef LINK_SUP_STATS_EN
        check("fade_cnt", o_fade_cnt, 1);
        check("relock_cnt_1", o_relock_cnt, 1);
`endif

        // Hard loss goes straight to SEARCH without a realign request
        rq_base = rq_cnt;
        sb_q.push_back(3);
        i_bit_locked      = 1'b0;
        i_bit_locked_soft = 1'b0;
        tick();
        check("hardloss_state", o_state, 3);
        ticks(10);
        check("hardloss_no_realign", rq_cnt - rq_base, 0);
        sb_q.push_back(5);
        i_bit_locked      = 1'b1;
        i_bit_locked_soft = 1'b1;
        tick();
        check("hardloss_relock", o_state, 5);

        // PHY loss outranks a simultaneous forced realign
        sb_q.push_back(1);
        i_rx_cdr_stable = 1'b0;
        i_force_realign = 1'b1;
        tick();
        i_force_realign = 1'b0;
        check("prio_phy_loss", o_state, 1);
        ticks(3);
        check("prio_wait_phy", o_state, 1);
        sb_q.push_back(2); sb_q.push_back(3); sb_q.push_back(5);
        i_rx_cdr_stable = 1'b1;
        wait_state(5, 30, "phy_back_lock");
        check("cfg_relatch_err_th", o_cfg_err_th, 20);
        check("cfg_relatch_verify", o_cfg_verify_cnt_max, 7);
        check("cfg_relatch_soft", o_cfg_soft_loss_to, 1000);
        check("cfg_relatch_hard", o_cfg_hard_loss_to, 2000);

        // Forced realign from LOCKED
        rq_base = rq_cnt;
        sb_q.push_back(2); sb_q.push_back(3); sb_q.push_back(5);
        i_force_realign = 1'b1;
        tick();
        i_force_realign = 1'b0;
        check("force_state", o_state, 2);
        wait_state(5, 30, "force_relock");
        check("force_realign_hold", rq_cnt - rq_base, 4);
`ifdef LINK_SUP_STATS_EN
        check("relock_cnt_4", o_relock_cnt, 4);
`endif
        check("sb_drain_locked", sb_q.size(), 0);

        // Retries, backoff and transceiver reset escalation
        gt_base = gt_cnt;
        sb_q.push_back(3); sb_q.push_back(4); sb_q.push_back(2); sb_q.push_back(3);
        sb_q.push_back(7); sb_q.push_back(1); sb_q.push_back(2); sb_q.push_back(3);
        i_bit_locked      = 1'b0;
        i_bit_locked_soft = 1'b0;
        wait_state(4, 150, "retry_backoff");
        check("search_timeout_len", dur_last, 100);
        check("retry_cnt_1", o_retry_cnt, 1);
        wait_state(2, 20, "backoff_done");
        check("backoff_len", dur_last, 8);
        wait_state(7, 150, "gt_reset_enter");
        check("retry_cnt_max", o_retry_cnt, 2);
        wait_state(1, 100, "gt_reset_done");
        check("gt_reset_width", gt_cnt - gt_base, 64);
        check("gt_reset_dwell", dur_last, 64);
        check("retry_cleared", o_retry_cnt, 0);
        wait_state(3, 20, "post_gt_search");
        check("sb_drain_retry", sb_q.size(), 0);

        // Asynchronous reset in the middle of BACKOFF
        sb_q.push_back(4);
        wait_state(4, 150, "backoff_again");
        check("backoff_retry", o_retry_cnt, 1);
        ticks(3);
        check("backoff_mid", o_state, 4);
        trace_en = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        ticks(2);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
